// File: rtl/core_sequencer.sv
// core_sequencer: runs one full convolution (clear, weight feed, activation feed, drain per kij, then readout)
// Optional cycle counter on perf_cycles when CORE_SEQ_PERF_CNT_EN is defined.
module core_sequencer #(
    parameter int ADDR_W    = 11,
    parameter int LEN_NIJ   = 36,
    parameter int LEN_KIJ   = 9,
    parameter int KIJ_W     = 4,
    parameter int MAC_COL   = 8,
    parameter int W_BASE    = 1024,
    parameter int LEN_ONIJ  = 16,
    parameter int CLR_CYC   = 10,
    parameter int DRAIN_CYC = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_2b,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              CEN_xmem,
    output logic              WEN_xmem,
    output logic [ADDR_W-1:0] A_xmem,
    output logic [1:0]        inst_w,
    output logic [KIJ_W-1:0]  kij,
    output logic              core_clr,
    output logic              readout_start,
    output logic              readout_valid,
    output logic [7:0]        out_idx,
    output logic [31:0]       perf_cycles
);
    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WLOAD, S_GAP, S_ALOAD, S_DRAIN, S_RDSTART, S_RDGAP, S_READOUT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d, len, wlen;
    logic [KIJ_W-1:0]  kij_q, kij_d;
    logic              two_q, two_d;
    logic              held, go, last;
    logic [ADDR_W-1:0] waddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            two_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            two_q   <= two_d;
        end
    end

    assign busy = state_q != S_IDLE && state_q != S_DONE;
    assign held = hold && busy;
    assign go   = state_q == S_IDLE && start;
    assign wlen = two_q ? 16'(2 * MAC_COL) : 16'(MAC_COL);
    assign len  = state_q == S_CLR     ? 16'(CLR_CYC)   :
                  state_q == S_WLOAD   ? wlen           :
                  state_q == S_ALOAD   ? 16'(LEN_NIJ)   :
                  state_q == S_DRAIN   ? 16'(DRAIN_CYC) :
                  state_q == S_READOUT ? 16'(LEN_ONIJ)  : 16'd1;
    assign last = cnt_q == len - 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        two_d   = two_q;
        if (go) begin
            state_d = S_CLR;
            two_d   = mode_2b;
            kij_d   = '0;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
            kij_d   = '0;
        end else if (busy && !held) begin
            cnt_d = last ? '0 : cnt_q + 16'd1;
            if (last) begin
                case (state_q)
                    S_CLR:     state_d = S_WLOAD;
                    S_WLOAD:   state_d = S_GAP;
                    S_GAP:     state_d = S_ALOAD;
                    S_ALOAD:   state_d = S_DRAIN;
                    S_DRAIN: begin
                        state_d = kij_q == KIJ_W'(LEN_KIJ - 1) ? S_RDSTART : S_CLR;
                        kij_d   = kij_q == KIJ_W'(LEN_KIJ - 1) ? kij_q : kij_q + KIJ_W'(1);
                    end
                    S_RDSTART: state_d = S_RDGAP;
                    S_RDGAP:   state_d = S_READOUT;
                    S_READOUT: state_d = S_DONE;
                    default:   state_d = state_q;
                endcase
            end
        end
    end

    // Address is a pure function of frozen state, so it naturally holds during a stall.
    assign waddr = ADDR_W'(W_BASE) + ADDR_W'(kij_q) * ADDR_W'(wlen) + ADDR_W'(cnt_q);

    always_comb begin
        done          = state_q == S_DONE;
        WEN_xmem      = 1'b1;
        CEN_xmem      = !((state_q == S_WLOAD || state_q == S_ALOAD) && !held);
        A_xmem        = state_q == S_WLOAD ? waddr : state_q == S_ALOAD ? ADDR_W'(cnt_q) : '0;
        inst_w        = held ? 2'b00 : state_q == S_WLOAD ? 2'b01 : state_q == S_ALOAD ? 2'b10 : 2'b00;
        kij           = kij_q;
        core_clr      = state_q == S_CLR && !held;
        readout_start = state_q == S_RDSTART && !held;
        readout_valid = state_q == S_READOUT && !held;
        out_idx       = state_q == S_READOUT ? cnt_q[7:0] : '0;
    end

`ifdef CORE_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_d      = go ? '0 : busy ? perf_q + 32'd1 : perf_q;
    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized run-level bench against a step-list reference model of the sequencer.
module tb_core_sequencer;
    localparam int ADDR_W = 11, LEN_NIJ = 36, LEN_KIJ = 9, MAC_COL = 8, W_BASE = 1024;
    localparam int LEN_ONIJ = 16, CLR_CYC = 10, DRAIN_CYC = 30;
`ifdef CORE_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, start2 = 1'b0, mode_2b = 1'b0, hold = 1'b0;
    logic busy, done, CEN_xmem, WEN_xmem, core_clr, readout_start, readout_valid;
    logic [ADDR_W-1:0] A_xmem;
    logic [1:0] inst_w;
    logic [3:0] kij;
    logic [7:0] out_idx;
    logic [31:0] perf_cycles;
    logic busy2, done2, cen2, wen2, clr2, rs2, rv2;
    logic [ADDR_W-1:0] a2;
    logic [1:0] inst2;
    logic [3:0] kij2;
    logic [7:0] oidx2;
    logic [31:0] perf2;
    logic [31:0] obs;

    always #5 clk = ~clk;

    core_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode_2b(mode_2b), .hold(hold),
        .busy(busy), .done(done), .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem),
        .inst_w(inst_w), .kij(kij), .core_clr(core_clr), .readout_start(readout_start),
        .readout_valid(readout_valid), .out_idx(out_idx), .perf_cycles(perf_cycles)
    );

    core_sequencer #(.LEN_KIJ(1), .LEN_NIJ(4), .MAC_COL(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode_2b(mode_2b), .hold(hold),
        .busy(busy2), .done(done2), .CEN_xmem(cen2), .WEN_xmem(wen2), .A_xmem(a2),
        .inst_w(inst2), .kij(kij2), .core_clr(clr2), .readout_start(rs2),
        .readout_valid(rv2), .out_idx(oidx2), .perf_cycles(perf2)
    );

    assign obs = {busy, done, CEN_xmem, WEN_xmem, inst_w, kij, core_clr, readout_start,
                  readout_valid, out_idx, A_xmem};

    typedef struct {
        bit b, d, cen;
        bit [1:0] inst;
        int k;
        bit clr, rs, rv;
        int o, a;
    } step_t;

    step_t steps[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic step_t mk(bit b, bit d, bit cen, bit [1:0] inst, int k,
                                 bit clr, bit rs, bit rv, int o, int a);
        step_t s;
        s.b = b; s.d = d; s.cen = cen; s.inst = inst; s.k = k;
        s.clr = clr; s.rs = rs; s.rv = rv; s.o = o; s.a = a;
        return s;
    endfunction

    function automatic logic [31:0] pk(step_t s);
        return {s.b, s.d, s.cen, 1'b1, s.inst, 4'(s.k), s.clr, s.rs, s.rv, 8'(s.o), 11'(s.a)};
    endfunction

    // Whole run as an ordered list of per-cycle outputs, written straight from the schedule.
    task automatic build(input int wpc);
        steps.delete();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int i = 0; i < CLR_CYC; i++)        steps.push_back(mk(1, 0, 1, 2'b00, k, 1, 0, 0, 0, 0));
            for (int t = 0; t < MAC_COL * wpc; t++)  steps.push_back(mk(1, 0, 0, 2'b01, k, 0, 0, 0, 0,
                                                                       W_BASE + k * MAC_COL * wpc + t));
            steps.push_back(mk(1, 0, 1, 2'b00, k, 0, 0, 0, 0, 0));
            for (int t = 0; t < LEN_NIJ; t++)        steps.push_back(mk(1, 0, 0, 2'b10, k, 0, 0, 0, 0, t));
            for (int i = 0; i < DRAIN_CYC; i++)      steps.push_back(mk(1, 0, 1, 2'b00, k, 0, 0, 0, 0, 0));
        end
        steps.push_back(mk(1, 0, 1, 2'b00, LEN_KIJ - 1, 0, 1, 0, 0, 0));
        steps.push_back(mk(1, 0, 1, 2'b00, LEN_KIJ - 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < LEN_ONIJ; i++)           steps.push_back(mk(1, 0, 1, 2'b00, LEN_KIJ - 1, 0, 0, 1, i, 0));
        steps.push_back(mk(0, 1, 1, 2'b00, LEN_KIJ - 1, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input bit two, input bit rnd, input int hold_at, input int hold_len, input int abort_at);
        step_t idle, e;
        int idx = 0, hc = 0, held_n = 0, busy_mod = 0, busy_dut = 0, dones = 0, cyc = 0;
        int wpc;
        bit h, hh;
        wpc = two ? 2 : 1;
        idle = mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        build(wpc);
        start = 1'b1; mode_2b = two; hold = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_pre", obs, pk(idle));
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < steps.size() && cyc < 4000) begin
            cyc++;
            e = steps[idx];
            if (idx == hold_at && hc < hold_len) begin
                h = 1'b1;
                hc++;
            end else h = rnd && $urandom_range(0, 9) == 0;
            hold = h;
            start = rnd && $urandom_range(0, 7) == 0;
            mode_2b = 1'($urandom_range(0, 1));
            hh = h && e.b;
            if (hh) begin
                e.cen = 1; e.inst = 2'b00; e.clr = 0; e.rs = 0; e.rv = 0;
                held_n++;
            end
            @(negedge clk);
            chk("cyc", obs, pk(e));
            busy_dut += int'(busy);
            dones += int'(done);
            if (e.d) chk("perf", perf_cycles, PERF ? busy_mod : 0);
            if (e.b) busy_mod++;
            if (idx == abort_at) begin
                #2 reset = 1'b0;
                #1 chk("rst_mid", {obs, perf_cycles}, {pk(idle), 32'd0});
                @(posedge clk); #1;
                reset = 1'b1; start = 1'b0; hold = 1'b0;
                return;
            end
            if (!hh) idx++;
            @(posedge clk); #1;
        end
        if (idx < steps.size()) chk("timeout", idx, steps.size());
        hold = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_post", obs, pk(idle));
        chk("perf_keep", perf_cycles, PERF ? busy_mod : 0);
        chk("busy_cyc", busy_dut,
            LEN_KIJ * (CLR_CYC + MAC_COL * wpc + 1 + LEN_NIJ + DRAIN_CYC) + 2 + LEN_ONIJ + held_n);
        chk("done_n", dones, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_small();
        int b2 = 0, d2 = 0, nw = 0, w0 = -1, w1 = -1;
        start2 = 1'b1; mode_2b = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst2 == 2'b01) begin
                if (nw == 0) w0 = int'(a2);
                if (nw == 1) w1 = int'(a2);
                nw++;
            end
            if (done2) chk("u2_perf", perf2, PERF ? b2 : 0);
            b2 += int'(busy2);
            d2 += int'(done2);
        end
        chk("u2_busy", b2, 1 * (CLR_CYC + 2 + 1 + 4 + DRAIN_CYC) + 2 + LEN_ONIJ);
        chk("u2_done", d2, 1);
        chk("u2_wn", nw, 2);
        chk("u2_w0", w0, W_BASE);
        chk("u2_w1", w1, W_BASE + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst0", {obs, perf_cycles}, {1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 3'b000, 8'd0, 11'd0, 32'd0});
        @(posedge clk); #1;
        reset = 1'b1;
        run(0, 0, -1, 0, -1);
        run(1, 0, -1, 0, -1);
        run(0, 0, CLR_CYC + MAC_COL + 1 + 10, 5, -1);
        run(0, 0, -1, 0, 4 * (CLR_CYC + MAC_COL + 1 + LEN_NIJ + DRAIN_CYC) + CLR_CYC + MAC_COL + 1 + LEN_NIJ + 5);
        run(0, 1, -1, 0, -1);
        run(1, 1, -1, 0, -1);
        run_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Hardware replacement for the bench-driven instruction stream of the systolic core.
- Once activations and all per-kij weights are preloaded in X_MEM, one `start` pulse runs the full convolution: per kij, a core clear, weight feed to L0, activation feed, PSUM drain; then the readout handshake.
- Generalised over nij/kij/column counts, 1- or 2-word-per-column weight packing (4-bit vs 2-bit activation mode), and a `hold` stall.
- Sits between the top-level controller and `core`, driving its X_MEM and instruction pins.

Parameters:
- ADDR_W, 11, X_MEM address width
- LEN_NIJ, 36, activation words fed per kij (X_MEM addresses 0..LEN_NIJ-1)
- LEN_KIJ, 9, kernel positions
- KIJ_W, 4, width of kij output
- MAC_COL, 8, weight columns per kij
- W_BASE, 1024, X_MEM address of kij0 weights
- LEN_ONIJ, 16, output words read out
- CLR_CYC, 10, core_clr length per kij
- DRAIN_CYC, 30, idle cycles after activation feed

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  begin run; sampled only in IDLE
- mode_2b  in  1  1 = two weight words per column; latched at start
- hold  in  1  stall request
- busy  out  1  high from cycle after start until DONE
- done  out  1  one-cycle pulse in DONE
- CEN_xmem  out  1  X_MEM chip enable, active-low
- WEN_xmem  out  1  X_MEM write enable; constant 1 (read-only)
- A_xmem  out  ADDR_W  X_MEM address
- inst_w  out  2  01 = weight load, 10 = activation load, 00 = nop
- kij  out  KIJ_W  current kernel index, to SFU
- core_clr  out  1  array/L0 clear
- readout_start  out  1  readout request pulse
- readout_valid  out  1  core readout port holds word out_idx
- out_idx  out  8  output word index
- perf_cycles  out  32  see Optional Feature

Behaviour:
- Outputs are decoded from registered state and counters; they are valid in the same cycle as the state.
- Reset (any time, including mid-run): IDLE; counters 0; busy=0, done=0, CEN=1, WEN=1, A=0, inst_w=00, kij=0, core_clr=0, readout_start=0, readout_valid=0, out_idx=0.
- IDLE:
  - Outputs at reset values.
  - start=1 → latch wpc = mode_2b ? 2 : 1 → CLR.
- CLR:
  - core_clr=1 for CLR_CYC cycles → WLOAD.
- WLOAD:
  - CEN=0, inst_w=01 for MAC_COL*wpc cycles.
  - A = W_BASE + kij*MAC_COL*wpc + t, with t = 0..MAC_COL*wpc-1.
  - In 2-bit mode the words alternate tile1, tile0, matching X_MEM packing.
  - → GAP.
- GAP:
  - 1 cycle; CEN=1, inst_w=00, A=0 → ALOAD.
- ALOAD:
  - CEN=0, inst_w=10, A = t for t = 0..LEN_NIJ-1 → DRAIN.
- DRAIN:
  - CEN=1, inst_w=00 for DRAIN_CYC cycles.
  - If kij == LEN_KIJ-1 → RDSTART; otherwise kij++ → CLR.
- RDSTART:
  - readout_start=1 for 1 cycle → RDGAP.
- RDGAP:
  - 1 cycle → READOUT.
- READOUT:
  - readout_valid=1 for LEN_ONIJ cycles; out_idx = 0..LEN_ONIJ-1 → DONE.
- DONE:
  - done=1 and busy=0 for 1 cycle → IDLE.
- busy is 1 in every state except IDLE and DONE.
- hold=1 in any busy state:
  - State and all counters freeze.
  - CEN=1, inst_w=00, core_clr=0, readout_start=0, readout_valid=0.
  - A, kij and out_idx keep their values.
  - On release, the interrupted step is reissued in the first cycle, so no address is skipped or duplicated.
  - readout_start is never split: hold during RDSTART delays the pulse.
- start while busy: ignored. start in the DONE cycle: ignored.
- mode_2b changes during a run: ignored.
- kij has no wrap: the run ends after LEN_KIJ-1.
- Address arithmetic is unsigned, truncated to ADDR_W.
- Integration must ensure W_BASE + LEN_KIJ*MAC_COL*2 ≤ 2^ADDR_W; this is not checked in hardware.
- Run length without hold: LEN_KIJ*(CLR_CYC + MAC_COL*wpc + 1 + LEN_NIJ + DRAIN_CYC) + 2 + LEN_ONIJ.

Optional Feature:
- Macro: CORE_SEQ_PERF_CNT_EN.
- Defined:
  - perf_cycles clears on start.
  - It increments every busy cycle, including held cycles.
  - It holds its value after done until the next start.
- Undefined: perf_cycles is tied to 0 and no counter is built.

Test Plan:
- Defaults, mode_2b=0, start pulse, hold=0 → done 783 cycles after busy rises; kij steps 0..8; WLOAD addresses 1024..1031 at kij0 and 1088..1095 at kij8; 36 ALOAD reads 0..35 per kij; perf_cycles=783 with the macro, 0 without.
- mode_2b=1 → 16 WLOAD reads per kij (kij3: addresses 1072..1087); total 855 cycles.
- hold=1 for 5 cycles at ALOAD t=10 → CEN=1, inst_w=00, A stays 10; after release A=10,11,…; done delayed exactly 5 cycles.
- reset asserted at kij=4 during DRAIN → all outputs at reset values immediately; a new start re-runs from kij=0.
- start pulsed at kij=2 during busy → no effect; single done pulse; out_idx 0..15 with readout_valid for 16 cycles, readout_start 2 cycles before the first valid.
- LEN_KIJ=1, LEN_NIJ=4, MAC_COL=2 → total 10+2+1+4+30+2+16 = 65 cycles; done pulses once.
